// File: rtl/csr_access_sequencer.sv
// csr_access_sequencer
//   Arbitrates the CSR file's single read/write port between two requesters:
//   - Zicsr instructions (read-modify-write using the forwarded RS1 / uimm operand)
//   - the trap unit (writes mepc, then mcause, then mstatus)
//   The trap unit always wins. busy_o stalls the front-end while a sequence is in flight.
//
// Ports
//   clk_i, rst_ni         clock (rising edge), asynchronous active-low reset
//   instr_valid_i/ready_o Zicsr op handshake; ready is combinational
//   instr_op_i            01 RW, 10 RS, 11 RC, 00 read-only
//   instr_addr_i          target CSR address
//   instr_src_i           RS1 value or zero-extended uimm
//   instr_src_zero_i      rs1/uimm field is x0/0 (suppresses RS/RC write)
//   instr_done_o          one-cycle pulse when the op completes
//   instr_rdata_o         old CSR value for rd, held until the next op reads
//   trap_req_i            level request, held until trap_ack_o
//   trap_cause_i          value for mcause
//   trap_pc_i             faulting PC (written to mepc word-aligned)
//   trap_ack_o            one-cycle pulse with the mstatus write
//   csr_raddr_o           CSR file read address (file answers in the same cycle)
//   csr_rdata_i           CSR file read data
//   csr_we_o/waddr_o/wdata_o  CSR file write port
//   busy_o                sequencer not idle
module csr_access_sequencer #(
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
    parameter logic [11:0] MSTATUS_ADDR = 12'h300
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [1:0]  instr_op_i,
    input  logic [11:0] instr_addr_i,
    input  logic [31:0] instr_src_i,
    input  logic        instr_src_zero_i,
    output logic        instr_done_o,
    output logic [31:0] instr_rdata_o,
    input  logic        trap_req_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_pc_i,
    output logic        trap_ack_o,
    output logic [11:0] csr_raddr_o,
    input  logic [31:0] csr_rdata_i,
    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        StIdle,
        StIRd,
        StIWr,
        StTEpc,
        StTCause,
        StTStat
    } state_e;

    state_e state_q, state_d;

    // Captured instruction / trap operands
    logic [1:0]  op_q;
    logic [11:0] addr_q;
    logic [31:0] src_q;
    logic        src_zero_q;
    logic [31:0] cause_q;

    // Registered outputs and their next values
    logic        instr_done_q, instr_done_d;
    logic [31:0] instr_rdata_q, instr_rdata_d;
    logic        trap_ack_q, trap_ack_d;
    logic [11:0] csr_raddr_q, csr_raddr_d;
    logic        csr_we_q, csr_we_d;
    logic [11:0] csr_waddr_q, csr_waddr_d;
    logic [31:0] csr_wdata_q, csr_wdata_d;

    logic [31:0] rmw_value;
    logic        rmw_write_en;
    logic [31:0] mstatus_trap;

    // Read-modify-write result from the old value on the read port
    always_comb begin
        case (op_q)
            2'b01:   rmw_value = src_q;
            2'b10:   rmw_value = csr_rdata_i | src_q;
            2'b11:   rmw_value = csr_rdata_i & ~src_q;
            default: rmw_value = csr_rdata_i;
        endcase
    end

    // RW always writes; RS/RC write only with a non-zero source field; read-only never writes
    assign rmw_write_en = (op_q == 2'b01) || ((op_q != 2'b00) && !src_zero_q);

    // mstatus on trap entry: MPIE <= MIE, MIE <= 0, MPP <= M
    always_comb begin
        mstatus_trap        = csr_rdata_i;
        mstatus_trap[7]     = csr_rdata_i[3];
        mstatus_trap[3]     = 1'b0;
        mstatus_trap[12:11] = 2'b11;
    end

    // State register, operand capture and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            op_q          <= 2'b00;
            addr_q        <= 12'h000;
            src_q         <= 32'h0;
            src_zero_q    <= 1'b0;
            cause_q       <= 32'h0;
            instr_done_q  <= 1'b0;
            instr_rdata_q <= 32'h0;
            trap_ack_q    <= 1'b0;
            csr_raddr_q   <= 12'h000;
            csr_we_q      <= 1'b0;
            csr_waddr_q   <= 12'h000;
            csr_wdata_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && state_d == StIRd) begin
                op_q       <= instr_op_i;
                addr_q     <= instr_addr_i;
                src_q      <= instr_src_i;
                src_zero_q <= instr_src_zero_i;
            end
            // StTEpc is only ever entered, never held, so this fires once per trap
            if (state_d == StTEpc) begin
                cause_q <= trap_cause_i;
            end
            instr_done_q  <= instr_done_d;
            instr_rdata_q <= instr_rdata_d;
            trap_ack_q    <= trap_ack_d;
            csr_raddr_q   <= csr_raddr_d;
            csr_we_q      <= csr_we_d;
            csr_waddr_q   <= csr_waddr_d;
            csr_wdata_q   <= csr_wdata_d;
        end
    end

    // Next-state logic; trap requests pre-empt idle accepts and pending reads
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (trap_req_i) begin
                    state_d = StTEpc;
                end else if (instr_valid_i) begin
                    state_d = StIRd;
                end
            end
            StIRd:    state_d = trap_req_i ? StTEpc : StIWr;
            StIWr:    state_d = StIdle;
            StTEpc:   state_d = StTCause;
            StTCause: state_d = StTStat;
            StTStat:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output decode from next state, so every port output is a flop
    always_comb begin
        instr_done_d  = 1'b0;
        instr_rdata_d = instr_rdata_q;
        trap_ack_d    = 1'b0;
        csr_raddr_d   = csr_raddr_q;
        csr_we_d      = 1'b0;
        csr_waddr_d   = csr_waddr_q;
        csr_wdata_d   = csr_wdata_q;
        case (state_d)
            StIRd: begin
                csr_raddr_d = instr_addr_i;
            end
            StIWr: begin
                csr_we_d      = rmw_write_en;
                csr_waddr_d   = addr_q;
                csr_wdata_d   = rmw_value;
                instr_done_d  = 1'b1;
                instr_rdata_d = csr_rdata_i;
            end
            StTEpc: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = MEPC_ADDR;
                csr_wdata_d = trap_pc_i & ~32'h3;
            end
            StTCause: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = MCAUSE_ADDR;
                csr_wdata_d = cause_q;
                // Point the read port at mstatus one cycle early so the registered
                // mstatus write data is ready for StTStat; the address stays put there.
                csr_raddr_d = MSTATUS_ADDR;
            end
            StTStat: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = MSTATUS_ADDR;
                csr_wdata_d = mstatus_trap;
                trap_ack_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign instr_ready_o = (state_q == StIdle) && !trap_req_i;
    assign busy_o        = (state_q != StIdle);
    assign instr_done_o  = instr_done_q;
    assign instr_rdata_o = instr_rdata_q;
    assign trap_ack_o    = trap_ack_q;
    assign csr_raddr_o   = csr_raddr_q;
    assign csr_we_o      = csr_we_q;
    assign csr_waddr_o   = csr_waddr_q;
    assign csr_wdata_o   = csr_wdata_q;

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Bench for csr_access_sequencer: a small CSR file model drives the read port, a
// transaction-level reference model predicts every cycle's outputs, directed cases pin
// the model with literal values, then randomized instructions and traps run.
module tb_csr_access_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [1:0]  instr_op = 2'b00;
    logic [11:0] instr_addr = 12'h000;
    logic [31:0] instr_src = 32'h0;
    logic        instr_src_zero = 1'b0;
    logic        instr_done;
    logic [31:0] instr_rdata;
    logic        trap_req = 1'b0;
    logic [31:0] trap_cause = 32'h0;
    logic [31:0] trap_pc = 32'h0;
    logic        trap_ack;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        busy;

    always #5 clk = ~clk;

    csr_access_sequencer dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .instr_valid_i   (instr_valid),
        .instr_ready_o   (instr_ready),
        .instr_op_i      (instr_op),
        .instr_addr_i    (instr_addr),
        .instr_src_i     (instr_src),
        .instr_src_zero_i(instr_src_zero),
        .instr_done_o    (instr_done),
        .instr_rdata_o   (instr_rdata),
        .trap_req_i      (trap_req),
        .trap_cause_i    (trap_cause),
        .trap_pc_i       (trap_pc),
        .trap_ack_o      (trap_ack),
        .csr_raddr_o     (csr_raddr),
        .csr_rdata_i     (csr_rdata),
        .csr_we_o        (csr_we),
        .csr_waddr_o     (csr_waddr),
        .csr_wdata_o     (csr_wdata),
        .busy_o          (busy)
    );

    // ---------------- CSR file model (five implemented CSRs) ----------------
    logic [11:0] addr_tab [5] = '{12'h340, 12'h341, 12'h342, 12'h300, 12'h305};
    logic [31:0] file_q [5];
    logic        load_en = 1'b0;
    logic [2:0]  load_idx = 3'd0;
    logic [31:0] load_val = 32'h0;
    int          ridx;
    int          widx;

    function automatic int aidx(input logic [11:0] a);
        for (int i = 0; i < 5; i++) begin
            if (addr_tab[i] == a) return i;
        end
        return -1;
    endfunction

    assign ridx = aidx(csr_raddr);
    assign widx = aidx(csr_waddr);
    assign csr_rdata = (ridx >= 0) ? file_q[ridx[2:0]] : 32'h0;

    always @(posedge clk) begin
        if (load_en) file_q[load_idx] <= load_val;
        else if (csr_we && widx >= 0) file_q[widx[2:0]] <= csr_wdata;
    end

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // m_kind: 0 nothing in flight, 1 instruction, 2 trap; m_age counts cycles since start.
    logic [31:0] exp_mem [5];
    int          m_kind = 0;
    int          m_age = 0;
    logic [1:0]  m_op;
    logic [11:0] m_addr;
    logic [31:0] m_src;
    logic        m_sz;
    logic [31:0] m_cause;
    logic        e_we = 0, e_done = 0, e_ack = 0, e_busy = 0, e_rchk = 0;
    logic [11:0] e_waddr = 0, e_raddr = 0;
    logic [31:0] e_wdata = 0, e_rdata = 0;

    initial begin : model
        logic [31:0] old, nv, ms;
        int          ai;
        logic        start_trap;
        forever begin
            @(posedge clk or negedge rst_n);
            if (clk && load_en) exp_mem[load_idx] = load_val;
            if (!rst_n) begin
                m_kind = 0; m_age = 0;
                e_we = 0; e_done = 0; e_ack = 0; e_busy = 0; e_rchk = 0;
                e_waddr = 0; e_wdata = 0; e_rdata = 0; e_raddr = 0;
            end else begin
                // the write shown last cycle lands in the file at this edge
                if (e_we) begin
                    ai = aidx(e_waddr);
                    exp_mem[ai[2:0]] = e_wdata;
                end
                e_we = 0; e_done = 0; e_ack = 0; e_rchk = 0;
                start_trap = 0;
                if (m_kind == 0) begin
                    if (trap_req) start_trap = 1;
                    else if (instr_valid) begin
                        m_kind = 1; m_age = 0;
                        m_op = instr_op; m_addr = instr_addr;
                        m_src = instr_src; m_sz = instr_src_zero;
                        e_rchk = 1; e_raddr = instr_addr;
                    end
                end else if (m_kind == 1 && m_age == 0) begin
                    if (trap_req) start_trap = 1;
                    else begin
                        m_age = 1;
                        ai = aidx(m_addr);
                        old = exp_mem[ai[2:0]];
                        case (m_op)
                            2'd1:    nv = m_src;
                            2'd2:    nv = old | m_src;
                            2'd3:    nv = old & ~m_src;
                            default: nv = old;
                        endcase
                        e_rdata = old;
                        e_done = 1;
                        if (m_op == 2'd1 || (m_op != 2'd0 && !m_sz)) begin
                            e_we = 1; e_waddr = m_addr; e_wdata = nv;
                        end
                    end
                end else if (m_kind == 1) begin
                    m_kind = 0;
                end else begin
                    m_age++;
                    if (m_age == 1) begin
                        e_we = 1; e_waddr = 12'h342; e_wdata = m_cause;
                    end else if (m_age == 2) begin
                        ms = exp_mem[3];
                        e_we = 1; e_waddr = 12'h300; e_ack = 1;
                        e_wdata = (ms & ~32'h1888) | 32'h1800 | ((ms & 32'h8) << 4);
                        e_rchk = 1; e_raddr = 12'h300;
                    end else begin
                        m_kind = 0;
                    end
                end
                if (start_trap) begin
                    m_kind = 2; m_age = 0; m_cause = trap_cause;
                    e_we = 1; e_waddr = 12'h341; e_wdata = {trap_pc[31:2], 2'b00};
                end
                e_busy = (m_kind != 0);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", {31'h0, busy}, {31'h0, e_busy});
            chk("csr_we", {31'h0, csr_we}, {31'h0, e_we});
            chk("instr_done", {31'h0, instr_done}, {31'h0, e_done});
            chk("trap_ack", {31'h0, trap_ack}, {31'h0, e_ack});
            chk("instr_rdata", instr_rdata, e_rdata);
            chk("instr_ready", {31'h0, instr_ready}, {31'h0, (m_kind == 0) && !trap_req});
            if (e_we) begin
                chk("csr_waddr", {20'h0, csr_waddr}, {20'h0, e_waddr});
                chk("csr_wdata", csr_wdata, e_wdata);
            end
            if (e_rchk) chk("csr_raddr", {20'h0, csr_raddr}, {20'h0, e_raddr});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_instr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] s,
                               input logic sz);
        instr_valid = 1'b1; instr_op = op; instr_addr = a; instr_src = s; instr_src_zero = sz;
    endtask

    logic [31:0] preload [5] = '{32'h0000000F, 32'h0, 32'h0, 32'h00000008, 32'hCAFE0001};

    initial begin
        // preload the CSR file (and model) while in reset
        for (int i = 0; i < 5; i++) begin
            step();
            load_en = 1'b1; load_idx = i[2:0]; load_val = preload[i];
        end
        step();
        load_en = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("reset busy", {31'h0, busy}, 32'h0);
        chk("reset csr_we", {31'h0, csr_we}, 32'h0);
        chk("reset done", {31'h0, instr_done}, 32'h0);
        chk("reset ack", {31'h0, trap_ack}, 32'h0);
        chk("reset rdata", instr_rdata, 32'h0);
        chk("reset waddr", {20'h0, csr_waddr}, 32'h0);
        chk("reset wdata", csr_wdata, 32'h0);
        chk("reset raddr", {20'h0, csr_raddr}, 32'h0);
        chk("reset ready", {31'h0, instr_ready}, 32'h1);
        step();

        // RS 0xF0 on mscratch=0xF
        drive_instr(2'b10, 12'h340, 32'hF0, 1'b0);
        step();
        instr_valid = 1'b0;
        chk("t1 raddr", {20'h0, csr_raddr}, 32'h340);
        chk("t1 busy", {31'h0, busy}, 32'h1);
        step();
        chk("t1 we", {31'h0, csr_we}, 32'h1);
        chk("t1 waddr", {20'h0, csr_waddr}, 32'h340);
        chk("t1 wdata", csr_wdata, 32'hFF);
        chk("t1 done", {31'h0, instr_done}, 32'h1);
        chk("t1 rdata", instr_rdata, 32'h0F);
        step();
        chk("t1 done drop", {31'h0, instr_done}, 32'h0);

        // RC with src_zero: done without write
        drive_instr(2'b11, 12'h340, 32'h0, 1'b1);
        step();
        instr_valid = 1'b0;
        step();
        chk("t2 done", {31'h0, instr_done}, 32'h1);
        chk("t2 we", {31'h0, csr_we}, 32'h0);
        chk("t2 rdata", instr_rdata, 32'hFF);
        step();

        // trap and instruction together in IDLE
        drive_instr(2'b01, 12'h305, 32'h123, 1'b0);
        trap_req = 1'b1; trap_cause = 32'h2; trap_pc = 32'h80000106;
        #1;
        chk("t3 ready", {31'h0, instr_ready}, 32'h0);
        step();
        instr_valid = 1'b0;
        chk("t3 mepc addr", {20'h0, csr_waddr}, 32'h341);
        chk("t3 mepc data", csr_wdata, 32'h80000104);
        chk("t3 ack early", {31'h0, trap_ack}, 32'h0);
        step();
        chk("t3 mcause addr", {20'h0, csr_waddr}, 32'h342);
        chk("t3 mcause data", csr_wdata, 32'h2);
        step();
        chk("t3 mstatus addr", {20'h0, csr_waddr}, 32'h300);
        chk("t3 mstatus data", csr_wdata, 32'h1880);
        chk("t3 ack", {31'h0, trap_ack}, 32'h1);
        trap_req = 1'b0;
        step();
        chk("t3 idle", {31'h0, busy}, 32'h0);

        // trap during I_RD aborts the instruction
        drive_instr(2'b01, 12'h342, 32'hAAAA, 1'b0);
        step();
        instr_valid = 1'b0;
        trap_req = 1'b1; trap_cause = 32'h7; trap_pc = 32'h100;
        step();
        chk("t4 mepc addr", {20'h0, csr_waddr}, 32'h341);
        chk("t4 no done", {31'h0, instr_done}, 32'h0);
        step();
        step();
        chk("t4 ack", {31'h0, trap_ack}, 32'h1);
        trap_req = 1'b0;
        step();

        // trap during I_WR: write completes, trap two cycles later; then reset in T_CAUSE
        drive_instr(2'b01, 12'h340, 32'h5A5A, 1'b0);
        step();
        instr_valid = 1'b0;
        step();
        trap_req = 1'b1; trap_cause = 32'h3; trap_pc = 32'h200;
        chk("t5 done", {31'h0, instr_done}, 32'h1);
        chk("t5 wdata", csr_wdata, 32'h5A5A);
        step();
        chk("t5 idle gap", {31'h0, busy}, 32'h0);
        chk("t5 idle we", {31'h0, csr_we}, 32'h0);
        step();
        chk("t5 mepc", {20'h0, csr_waddr}, 32'h341);
        chk("t5 mepc data", csr_wdata, 32'h200);
        step();
        chk("t6 in mcause", {20'h0, csr_waddr}, 32'h342);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6 we on reset", {31'h0, csr_we}, 32'h0);
        chk("t6 busy on reset", {31'h0, busy}, 32'h0);
        trap_req = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("t6 idle after", {31'h0, busy}, 32'h0);
        chk("t6 ready after", {31'h0, instr_ready}, 32'h1);
        step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (trap_req && trap_ack) trap_req = 1'b0;
            else if (!trap_req && $urandom_range(0, 15) == 0) begin
                trap_req = 1'b1; trap_cause = $urandom; trap_pc = $urandom;
            end
            instr_valid = ($urandom_range(0, 3) != 0);
            instr_op = 2'($urandom_range(0, 3));
            instr_addr = addr_tab[$urandom_range(0, 4)];
            instr_src_zero = ($urandom_range(0, 3) == 0);
            instr_src = instr_src_zero ? 32'h0 : $urandom;
            step();
        end
        instr_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (trap_req && trap_ack) trap_req = 1'b0;
            step();
        end
        trap_req = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) chk("final csr contents", file_q[i], exp_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
